// File: rtl/mudi_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, default latencies,
// FSM state encoding and the HI:LO result type.
package mudi_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  // Codes held back for the multiply-accumulate extension.
  localparam logic [3:0] OP_RSV_FIRST = OP_MADD;
  localparam logic [3:0] OP_RSV_LAST  = OP_MSUBU;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// E-stage request/response bundle between the pipeline (master) and the
// multiply/divide unit (slave).
interface mult_div_unit_if;
  logic        Start;
  logic [3:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cancel;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, Op, A, B, Cancel, input Busy, HI, LO);
  modport slave  (input Start, Op, A, B, Cancel, output Busy, HI, LO);
endinterface

// File: rtl/mudi_arith.sv
// Combinational multiply/divide datapath; optional accumulate ops are built
// only when MUDI_MADD_EN is defined.
module mudi_arith
  import mudi_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output hilo_t       res,
  output logic        div_by_zero
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag, b_mag, b_mag_nz, b_nz;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
  assign a_mag    = a[31] ? -a : a;
  assign b_mag    = b[31] ? -b : b;
  assign b_mag_nz = (b == 32'd0) ? 32'd1 : b_mag;
  assign b_nz     = (b == 32'd0) ? 32'd1 : b;

  assign q_mag = a_mag / b_mag_nz;
  assign r_mag = a_mag % b_mag_nz;
  assign q_s   = (a[31] ^ b[31]) ? -q_mag : q_mag;
  assign r_s   = a[31] ? -r_mag : r_mag;
  assign q_u   = a / b_nz;
  assign r_u   = a % b_nz;

  always_comb begin
    res         = {hi, lo};
    div_by_zero = 1'b0;
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV: begin
        res         = {r_s, q_s};
        div_by_zero = (b == 32'd0);
      end
      OP_DIVU: begin
        res         = {r_u, q_u};
        div_by_zero = (b == 32'd0);
      end
`ifdef MUDI_MADD_EN
      OP_MADD:  res = {hi, lo} + prod_s;
      OP_MADDU: res = {hi, lo} + prod_u;
      OP_MSUB:  res = {hi, lo} - prod_s;
      OP_MSUBU: res = {hi, lo} - prod_u;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MIPS multiply/divide unit owning HI/LO; MUDI_MADD_EN enables
// the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mult_div_unit
  import mudi_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic             Clk,
  input logic             Reset,
  mult_div_unit_if.slave  bus
);

  if (MULT_CYCLES < 1 || MULT_CYCLES > 15) begin : g_bad_mult_cycles
    $error("MULT_CYCLES must be in 1..15");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
    $error("DIV_CYCLES must be in 1..15");
  end

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  logic [0:0]  state_q;
  logic [3:0]  cnt_q;
  logic        busy_q;
  logic        dz_q;
  hilo_t       res_q;
  logic [31:0] hi_q, lo_q;

  logic        op_legal;
  logic        accept;
  hilo_t       arith_res;
  logic        arith_dz;

`ifdef MUDI_MADD_EN
  assign op_legal = (bus.Op != OP_NONE) && (bus.Op <= OP_RSV_LAST);
`else
  assign op_legal = (bus.Op != OP_NONE) && (bus.Op < OP_RSV_FIRST);
`endif

  assign accept = bus.Start && !bus.Cancel && !busy_q && op_legal;

  mudi_arith u_arith (
    .op          (bus.Op),
    .a           (bus.A),
    .b           (bus.B),
    .hi          (hi_q),
    .lo          (lo_q),
    .res         (arith_res),
    .div_by_zero (arith_dz)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (bus.Op == OP_MTHI) begin
              hi_q <= bus.A;
            end else if (bus.Op == OP_MTLO) begin
              lo_q <= bus.A;
            end else begin
              res_q   <= arith_res;
              dz_q    <= arith_dz;
              cnt_q   <= op_is_div(bus.Op) ? DIV_LAT : MULT_LAT;
              busy_q  <= 1'b1;
              state_q <= ST_RUN;
            end
          end
        end
        default: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            // A zero divisor burns the full latency but leaves HI/LO alone.
            if (!dz_q) begin
              hi_q <= res_q.hi;
              lo_q <= res_q.lo;
            end
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.Busy = bus.Start | busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random ops
// against an arithmetic model of HI/LO; honours MUDI_MADD_EN.
module tb_mult_div_unit;
  import mudi_pkg::*;

  logic Clk;
  logic Reset;
  int   n_checks;
  int   n_fails;
  logic [31:0] m_hi, m_lo;

  mult_div_unit_if bus ();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [3:0] op);
`ifdef MUDI_MADD_EN
    return op >= 4'd1 && op <= 4'd10;
`else
    return op >= 4'd1 && op <= 4'd6;
`endif
  endfunction

  function automatic int latency(input logic [3:0] op);
    if (op == OP_DIV || op == OP_DIVU) return 10;
    if (op == OP_MTHI || op == OP_MTLO) return 0;
    return 5;
  endfunction

  // Architectural effect of an accepted op on the model HI:LO.
  task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    acc = {m_hi, m_lo};
    case (op)
      OP_MULT:  acc = sa * sb;
      OP_MULTU: acc = ua * ub;
      OP_DIV:   if (b != 0) acc = {32'(sa % sb), 32'(sa / sb)};
      OP_DIVU:  if (b != 0) acc = {32'(ua % ub), 32'(ua / ub)};
      OP_MTHI:  acc[63:32] = a;
      OP_MTLO:  acc[31:0] = a;
`ifdef MUDI_MADD_EN
      OP_MADD:  acc = acc + sa * sb;
      OP_MADDU: acc = acc + ua * ub;
      OP_MSUB:  acc = acc - sa * sb;
      OP_MSUBU: acc = acc - ua * ub;
`endif
      default: ;
    endcase
    {m_hi, m_lo} = acc;
  endtask

  // Called just after a negedge with Start low; returns at the first idle cycle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cancel, input string tag);
    int          n_exp, cnt;
    logic [31:0] old_hi, old_lo;
    bit          held, acc;
    check_val({tag, ":idle_before_start"}, bus.Busy, 1'b0);
    acc    = !cancel && legal(op);
    n_exp  = acc ? latency(op) : 0;
    old_hi = m_hi;
    old_lo = m_lo;
    bus.Start  = 1'b1;
    bus.Op     = op;
    bus.A      = a;
    bus.B      = b;
    bus.Cancel = cancel;
    #1;
    check_val({tag, ":busy_start"}, bus.Busy, 1'b1);
    if (acc) model_op(op, a, b);
    @(negedge Clk);
    bus.Start  = 1'b0;
    bus.Cancel = 1'b0;
    bus.Op     = 4'($urandom_range(0, 15));
    bus.A      = $urandom;
    bus.B      = $urandom;
    #1;
    cnt  = 0;
    held = 1'b1;
    while (bus.Busy && cnt < 40) begin
      if (bus.HI !== old_hi || bus.LO !== old_lo) held = 1'b0;
      cnt++;
      @(negedge Clk);
      #1;
    end
    check_val({tag, ":busy_cycles"}, cnt, n_exp);
    check_val({tag, ":hold"}, held, 1'b1);
    check_val({tag, ":HI"}, bus.HI, m_hi);
    check_val({tag, ":LO"}, bus.LO, m_lo);
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a, r_b;
    logic        r_cancel;
    n_checks   = 0;
    n_fails    = 0;
    Reset      = 1'b1;
    bus.Start  = 1'b0;
    bus.Op     = OP_NONE;
    bus.A      = 32'd0;
    bus.B      = 32'd0;
    bus.Cancel = 1'b0;
    m_hi       = 32'd0;
    m_lo       = 32'd0;
    repeat (3) @(negedge Clk);
    #1;
    check_val("reset:HI", bus.HI, 32'd0);
    check_val("reset:LO", bus.LO, 32'd0);
    check_val("reset:Busy", bus.Busy, 1'b0);
    Reset = 1'b0;

    run_op(OP_MULT,  32'hFFFFFFFE, 32'd3,        1'b0, "mult_neg");
    check_val("mult_neg:HI_const", bus.HI, 32'hFFFFFFFF);
    check_val("mult_neg:LO_const", bus.LO, 32'hFFFFFFFA);
    run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
    check_val("multu_max:HI_const", bus.HI, 32'hFFFFFFFE);
    check_val("multu_max:LO_const", bus.LO, 32'h00000001);
    run_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        1'b0, "div_neg");
    check_val("div_neg:HI_const", bus.HI, 32'hFFFFFFFF);
    check_val("div_neg:LO_const", bus.LO, 32'hFFFFFFFD);
    run_op(OP_DIVU,  32'd7,        32'd0,        1'b0, "divu_zero");
    run_op(OP_MTHI,  32'h12345678, 32'd0,        1'b0, "mthi");
    run_op(OP_MTLO,  32'h9ABCDEF0, 32'd0,        1'b0, "mtlo");
    check_val("mt_pair:HI_const", bus.HI, 32'h12345678);
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, "div_ovf");
    check_val("div_ovf:LO_const", bus.LO, 32'h80000000);
    check_val("div_ovf:HI_const", bus.HI, 32'h00000000);
    run_op(OP_MULT,  32'd5,        32'd7,        1'b1, "mult_cancel");
    run_op(OP_NONE,  32'd5,        32'd7,        1'b0, "op_none");

    // Reset in the third cycle of a divide abandons it and clears HI/LO.
    bus.Start = 1'b1; bus.Op = OP_DIV; bus.A = 32'd100; bus.B = 32'd7; bus.Cancel = 1'b0;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (2) @(negedge Clk);
    Reset     = 1'b1;
    bus.Start = 1'b1; bus.Op = OP_MTHI; bus.A = 32'hDEADBEEF;
    @(negedge Clk);
    bus.Start = 1'b0;
    #1;
    check_val("rst_mid_div:Busy", bus.Busy, 1'b0);
    check_val("rst_mid_div:HI", bus.HI, 32'd0);
    check_val("rst_mid_div:LO", bus.LO, 32'd0);
    Reset = 1'b0;
    m_hi  = 32'd0;
    m_lo  = 32'd0;

    run_op(OP_MTLO,  32'hFFFFFFFF, 32'd0, 1'b0, "madd_prep_lo");
    run_op(OP_MTHI,  32'd0,        32'd0, 1'b0, "madd_prep_hi");
    run_op(OP_MADDU, 32'd1,        32'd1, 1'b0, "maddu_carry");

    for (int i = 0; i < 40; i++) begin
      r_op     = 4'($urandom_range(0, 11));
      r_a      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      case ($urandom_range(0, 5))
        0:       r_b = 32'd0;
        1, 2:    r_b = 32'($urandom_range(0, 20)) - 32'd10;
        default: r_b = $urandom;
      endcase
      r_cancel = ($urandom_range(0, 5) == 0);
      run_op(r_op, r_a, r_b, r_cancel, $sformatf("rand%0d_op%0d", i, r_op));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit for the E stage of the MIPS pipeline. It owns the HI/LO registers and executes mult/multu/div/divu/mthi/mtlo over multiple cycles. It drives `Busy`, which the hazard unit consumes as `MuDiBusy` to stall D-stage mf/mt/mudi instructions. `HI`/`LO` feed the mfhi/mflo result path.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles after a multiply start (1..15).
- `DIV_CYCLES`, default 10: busy cycles after a divide start (1..15).

Ports:
- `Clk`  in  1  clock.
- `Reset`  in  1  reset Reset, synchronous, active-high; clock Clk.
- `Start`  in  1  E-stage instruction is a mudi/mt op; qualifies `Op`.
- `Op`  in  4  operation code, values from `mudi_pkg`.
- `A`  in  32  forwarded rs value.
- `B`  in  32  forwarded rt value.
- `Cancel`  in  1  exception/interrupt this cycle; suppresses a same-cycle `Start`.
- `Busy`  out  1  `Start | busy_q`, combinational.
- `HI`  out  32  architectural HI.
- `LO`  out  32  architectural LO.

## Operation
- Op codes:
  - 0 NONE
  - 1 MULT (signed)
  - 2 MULTU
  - 3 DIV (signed)
  - 4 DIVU
  - 5 MTHI
  - 6 MTLO
  - 7–10 reserved for MADD/MADDU/MSUB/MSUBU (see Configuration).
- Accepted start: `Start && !Cancel && !busy_q && Op != NONE`.
- Any other `Start` is ignored, with no state change. Start-while-busy is a protocol violation because the hazard unit prevents it; the bench asserts it never occurs.
- MTHI/MTLO: write `A` to HI/LO at the accepting edge. No busy phase.
- Multiply and divide use a two-state FSM, IDLE/RUN:
  - On the accepting edge: compute the result from `A`/`B` and register it into `res_hi`/`res_lo`, load the counter with the latency, and go to RUN.
  - In RUN: the counter decrements each edge. On the edge where the counter equals 1, commit `res_hi`/`res_lo` into HI/LO, clear `busy_q`, and go to IDLE.
- Multiply result: the 64-bit product. HI = product[63:32], LO = product[31:0]. Signed for MULT, zero-extended for MULTU.
- Divide result: LO = quotient, HI = remainder, truncating toward zero. The remainder takes the sign of the dividend.
- Divide by zero (`B == 0`): runs the full latency, then leaves HI/LO unchanged.
- DIV of 0x80000000 by 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- `Cancel` does not abort an operation already in RUN; it only gates a start.
- `HI`/`LO` never change while `busy_q` is high, except at the commit edge.

## Timing
- Reset values: HI = 0, LO = 0, `busy_q` = 0, counter = 0, FSM = IDLE. With `Start` low, `Busy` = 0.
- Reset mid-RUN abandons the operation and HI/LO go to 0.
- Reset has priority over `Start`.
- For a multiply or divide accepted at edge t0:
  - `Busy` is high in the start cycle and for N cycles after it (N = `MULT_CYCLES` or `DIV_CYCLES`).
  - HI/LO take the new value after edge t0+N.
  - A back-to-back start is accepted at edge t0+N+1 at the earliest.
- MTHI/MTLO accepted at edge t0: the value is visible after t0. `Busy` is high only in the start cycle (via `Start`).
- The counter is 4 bits wide. The parameters must be ≥ 1, checked by an elaboration-time assertion.

## Configuration
- `MUDI_MADD_EN` defined: Op 7–10 are legal and use `MULT_CYCLES` latency.
  - MADD: HI:LO += signed A*B.
  - MADDU: HI:LO += unsigned A*B.
  - MSUB: HI:LO -= signed A*B.
  - MSUBU: HI:LO -= unsigned A*B.
  - The accumulation uses the HI:LO value at commit, with 64-bit wrap-around.
- `MUDI_MADD_EN` undefined: Op 7–10 are treated as NONE and ignored, and the accumulate datapath is absent.

## Structure
- `mudi_pkg` holds:
  - the Op code localparams and the reserved range;
  - the default latency constants;
  - the FSM state encoding.
- Sub-module `mudi_arith` (combinational) takes `Op`, `A`, `B`, and the current HI/LO, and produces the 64-bit product/quotient/remainder and the div-by-zero flag.
- `mult_div_unit` keeps the FSM, counter, result registers and HI/LO.

## Test plan
- Reset → HI = 0, LO = 0, `Busy` = 0.
  - MULT A = 0xFFFFFFFE (-2), B = 3 → `Busy` high for 6 cycles; then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
- MULTU A = 0xFFFFFFFF, B = 0xFFFFFFFF → after 5 cycles, HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV A = -7, B = 2 → `Busy` high for 11 cycles; LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU 7/0 → HI/LO unchanged, `Busy` still high for 11 cycles.
- MTHI 0x12345678, next cycle MTLO 0x9ABCDEF0 → each is visible the following cycle; `Busy` is high only in each start cycle.
- MULT with `Cancel` = 1 → no busy phase, HI/LO unchanged.
  - Reset at cycle 3 of a DIV → HI = LO = 0, `Busy` = 0 the next cycle.
- With `MUDI_MADD_EN`, HI:LO = 0x0:0xFFFFFFFF, then MADDU 1×1 → HI = 1, LO = 0.
  - Without the macro, the same op leaves HI:LO unchanged and produces no busy phase.
